// File: rtl/payload_commit_buffer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | payload_commit_buffer: payload word FIFO that only exposes checksum-good  |
// | packets. Define DROP_COUNT_EN to enable the saturating drop counter.      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module payload_commit_buffer #(
  parameter int ADDR_W      = 6,
  parameter int LEN_DEPTH_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] data_in,
  input  logic [15:0] len_in,
  input  logic        ok_in,
  input  logic        fin_in,
  input  logic        rd_en,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        pkt_avail,
  output logic [15:0] pkt_len_out,
  output logic        last_out,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LQ_DEPTH = 1 << LEN_DEPTH_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]            mem [DEPTH];
  logic [15:0]            len_q [LQ_DEPTH];
  logic [ADDR_W-1:0]      wr_ptr, cmt_ptr, rd_ptr;
  logic [ADDR_W-1:0]      wr_ptr_inc, wr_ptr_next;
  logic [LEN_DEPTH_W-1:0] lq_wr, lq_rd;
  logic [LEN_DEPTH_W:0]   lq_cnt;
  logic [14:0]            rd_cnt;
  logic [14:0]            head_words;

  logic buf_full, lq_full;
  logic store, commit, drop;
  logic rd_fire, pop;

  assign wr_ptr_inc  = wr_ptr + 1'b1;
  assign buf_full    = (wr_ptr_inc == rd_ptr);
  assign lq_full     = (lq_cnt == LQ_DEPTH[LEN_DEPTH_W:0]);
  assign wr_ptr_next = store ? wr_ptr_inc : wr_ptr;

  assign pkt_avail   = (lq_cnt != '0);
  assign pkt_len_out = pkt_avail ? len_q[lq_rd] : 16'd0;
  assign head_words  = 15'((32'(pkt_len_out) + 32'd3) >> 2);
  assign rd_fire     = rd_en && pkt_avail;
  assign pop         = rd_fire && ((head_words == 15'd0) || (rd_cnt + 15'd1 == head_words));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The word of a same-cycle wr_en is resolved first; the commit decision then
  // looks at the state that word left the writer in.
  always_comb begin
    state_next = state;
    store      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: if (wr_en) begin
        if (!lq_full && !buf_full) begin
          store      = 1'b1;
          state_next = RECV;
        end else begin
          state_next = DROP;
        end
      end
      RECV: if (wr_en) begin
        if (!buf_full) store = 1'b1;
        else           state_next = DROP;
      end
      DROP: ;
      default: state_next = IDLE;
    endcase
    if (fin_in) begin
      case (state_next)
        RECV: begin
          commit = ok_in;
          drop   = !ok_in;
        end
        DROP: drop = 1'b1;
        default: begin
          if (ok_in && (len_in == 16'd0) && !lq_full) commit = 1'b1;
          else                                        drop   = 1'b1;
        end
      endcase
      state_next = IDLE;
    end
  end

  // Storage arrays carry no reset; pointers and counts alone define contents.
  always_ff @(posedge clk) begin
    if (store)  mem[wr_ptr]  <= data_in;
    if (commit) len_q[lq_wr] <= len_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      cmt_ptr   <= '0;
      rd_ptr    <= '0;
      lq_wr     <= '0;
      lq_rd     <= '0;
      lq_cnt    <= '0;
      rd_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      if (drop) wr_ptr <= cmt_ptr;
      else      wr_ptr <= wr_ptr_next;

      if (commit) begin
        cmt_ptr <= wr_ptr_next;
        lq_wr   <= lq_wr + 1'b1;
      end

      case ({commit, pop})
        2'b10:   lq_cnt <= lq_cnt + 1'b1;
        2'b01:   lq_cnt <= lq_cnt - 1'b1;
        default: lq_cnt <= lq_cnt;
      endcase

      if (rd_fire) begin
        valid_out <= 1'b1;
        last_out  <= pop;
        if (head_words == 15'd0) begin
          data_out <= '0;
        end else begin
          data_out <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
        end
        if (pop) begin
          rd_cnt <= '0;
          lq_rd  <= lq_rd + 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 15'd1;
        end
      end else begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
    end
  end

`ifdef DROP_COUNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset)                            drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/payload_commit_buffer.md
PAYLOAD_COMMIT_BUFFER -- requirements
Module: payload_commit_buffer

Interface
REQ-001 SHALL have parameters: ADDR_W, default 6, log2 of word-buffer depth (64 words); LEN_DEPTH_W, default 2, log2 of packet-length queue depth (4 packets).
REQ-002 SHALL have ports, one per line:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- wr_en  input  1  payload word valid, from decoder wr_en_tcp/wr_en_udp
- data_in  input  32  payload word; first byte in [31:24]
- len_in  input  16  payload byte length; sampled when fin_in=1
- ok_in  input  1  packet checksum good; sampled when fin_in=1
- fin_in  input  1  single-cycle end-of-packet pulse
- rd_en  input  1  pop one committed word
- data_out  output  32  read word, registered
- valid_out  output  1  data_out valid
- pkt_avail  output  1  at least one committed packet queued
- pkt_len_out  output  16  byte length of head committed packet
- last_out  output  1  with valid_out, marks final word of packet
- busy  output  1  writer not IDLE
- drop_cnt  output  16  dropped-packet count

Function
REQ-003 Writer FSM states SHALL be IDLE, RECV, DROP.
- IDLE: wr_en with length queue not full -> RECV, word stored; with queue full -> DROP.
- RECV: each wr_en stores at wr_ptr, wr_ptr++; store attempted while full -> DROP.
- DROP: words discarded.
- Any state: fin_in -> IDLE.
REQ-004 wr_en and fin_in in the same cycle SHALL store the word before the commit decision (word included in packet).
REQ-005 fin_in with ok_in=1 in RECV SHALL set cmt_ptr to the updated wr_ptr and push len_in into the length queue.
REQ-006 fin_in with ok_in=0, or fin_in in DROP, SHALL restore wr_ptr to cmt_ptr and increment the drop count.
REQ-007 fin_in in IDLE with no prior wr_en SHALL commit only when ok_in=1 and len_in=0; it pushes length 0 and stores no words.
REQ-008 Full SHALL mean wr_ptr+1 == rd_ptr, modulo 2^ADDR_W; pointers wrap naturally.
REQ-009 Uncommitted words SHALL never be readable.
REQ-010 pkt_avail SHALL be 1 while the length queue is non-empty, first asserting the cycle after the committing fin_in.
REQ-011 rd_en with pkt_avail=1 SHALL produce data_out/valid_out one cycle later and advance rd_ptr.
REQ-012 rd_en with pkt_avail=0 SHALL be ignored, with valid_out=0.
REQ-013 Reader SHALL count words against ceil(pkt_len_out/4).
REQ-014 On the final word of a packet, reader SHALL assert last_out with valid_out and pop the length queue.
REQ-015 A length-0 packet SHALL be popped by one rd_en returning valid_out=1, last_out=1, data_out=0.
REQ-016 Simultaneous write, commit and read SHALL each proceed independently in the same cycle.
REQ-017 drop_cnt SHALL saturate at 16'hFFFF.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 reset=1 SHALL, at the next clk edge, set state IDLE and all pointers, queue and counters to 0.
REQ-020 After reset: data_out=0, valid_out=0, last_out=0, pkt_avail=0, pkt_len_out=0, busy=0, drop_cnt=0.
REQ-021 Reset mid-packet SHALL discard all stored and committed data without counting a drop.

Configuration
REQ-022 With DROP_COUNT_EN defined, drop_cnt SHALL count per REQ-006 and REQ-017.
REQ-023 Without DROP_COUNT_EN, drop_cnt SHALL be tied to 0 and the counter register omitted; all other behaviour SHALL be identical.

Verification
REQ-024 Commit and read:
- write 48656c6c, 6f20576f, 726c6400; fin_in, ok_in=1, len_in=11 -> pkt_avail=1 next cycle, pkt_len_out=11
- 3 rd_en -> same words returned, last_out only on 726c6400
REQ-025 Bad checksum: same packet with ok_in=0 -> pkt_avail stays 0, wr_ptr back to 0, drop_cnt=1 (0 without DROP_COUNT_EN).
REQ-026 Overflow: ADDR_W=2, write 4-word packet, ok_in=1 -> DROP entered on 4th word; no commit; drop_cnt=1.
REQ-027 Back-to-back: commit 11-byte packet, then stream a second packet while reading the first -> first reads intact; second pkt_len_out correct after first packet's last_out.
REQ-028 Reset mid-packet: reset after 2 words -> all outputs at reset values; next 11-byte packet reads back correctly.
REQ-029 Queue full: commit 4 packets, nothing read -> 5th packet's first wr_en enters DROP; drop_cnt=1.
